ec_point_dbl_jb_seq: RTL and testbench

// - Sequential Jacobian point doubler for short-Weierstrass curves with a = 0 (secp256k1 by default), any modulus P.
// - Computes A=y^2, B=4xA, C=8A^2, D=3x^2, X'=D^2-2B, Y'=D(B-X')-C, Z'=2yz, all mod P.
// - Borrows one external modular multiplier through a request/response handshake; does mod add/sub internally.
// - Sits between the signature-verification point-multiply FSM and the shared multiplier arbiter.

---
 rtl/ec_point_dbl_jb_seq.sv | 197 +++++++++++++++++++
 tb/tb_ec_point_dbl_jb_seq.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ec_point_dbl_jb_seq.sv
// Sequential Jacobian point doubler (a = 0 curves) that borrows one external
// modular multiplier over valid/ready and does mod add/sub internally.
module ec_point_dbl_jb_seq #(
  parameter int unsigned         DAT_BITS = 256,
  parameter logic [DAT_BITS-1:0] P        = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [3*DAT_BITS-1:0] i_pt,
  input  logic                  i_val,
  output logic                  o_rdy,
  output logic [3*DAT_BITS-1:0] o_pt,
  output logic                  o_val,
  input  logic                  i_rdy,
  output logic [DAT_BITS-1:0]   o_mul_a,
  output logic [DAT_BITS-1:0]   o_mul_b,
  output logic                  o_mul_val,
  input  logic                  i_mul_rdy,
  input  logic [DAT_BITS-1:0]   i_mul_c,
  input  logic                  i_mul_c_val,
  output logic                  o_mul_c_rdy,
  output logic [2:0]            o_dbg_state
);
  // Handshakes: a transfer happens on any cycle where valid && ready; a valid
  // output keeps its payload stable until that cycle.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_MUL = 3'd1, S_WAIT = 3'd2, S_POST = 3'd3, S_DONE = 3'd4
  } state_t;

  localparam logic [DAT_BITS:0] P_EXT = {1'b0, P};

  state_t              state;
  logic [2:0]          step;
  logic [1:0]          pc;
  logic [1:0]          last_pc;
  logic [DAT_BITS-1:0] x, y, z, a, b, c, d, xo, zo, p0;
  logic [DAT_BITS-1:0] in_x, in_y, in_z;
  logic [DAT_BITS-1:0] op_a, op_b, r, nxt_a, nxt_b;
  logic                op_sub;

  assign in_x        = i_pt[3*DAT_BITS-1 -: DAT_BITS];
  assign in_y        = i_pt[2*DAT_BITS-1 -: DAT_BITS];
  assign in_z        = i_pt[DAT_BITS-1:0];
  assign o_dbg_state = state;

  function automatic logic [DAT_BITS-1:0] mod_add(input logic [DAT_BITS-1:0] fa,
                                                  input logic [DAT_BITS-1:0] fb);
    logic [DAT_BITS:0] s;
    s = {1'b0, fa} + {1'b0, fb};
    if (s >= P_EXT) s = s - P_EXT;
    return s[DAT_BITS-1:0];
  endfunction

  function automatic logic [DAT_BITS-1:0] mod_sub(input logic [DAT_BITS-1:0] fa,
                                                  input logic [DAT_BITS-1:0] fb);
    logic [DAT_BITS:0] s;
    s = {1'b0, fa} - {1'b0, fb};
    if (s[DAT_BITS]) s = s + P_EXT;
    return s[DAT_BITS-1:0];
  endfunction

  // Single shared add/sub unit; MUL only uses it for the B - X' operand of step 6.
  always_comb begin
    op_a   = p0;
    op_b   = p0;
    op_sub = 1'b0;
    if (state == S_MUL) begin
      op_a   = b;
      op_b   = xo;
      op_sub = 1'b1;
    end else begin
      case (step)
        3'd1: if (pc != 2'd0) op_a = d;
        3'd3: if (pc != 2'd0) begin op_a = b; op_b = b; end
        3'd4: if (pc != 2'd0) begin op_a = c; op_b = c; end
        3'd5: begin op_sub = 1'b1; op_b = b; if (pc != 2'd0) op_a = xo; end
        3'd6: begin op_sub = 1'b1; op_b = c; end
        default: ;
      endcase
    end
    r = op_sub ? mod_sub(op_a, op_b) : mod_add(op_a, op_b);
  end

  always_comb begin
    case (step)
      3'd1, 3'd3, 3'd5: last_pc = 2'd1;
      3'd4:             last_pc = 2'd2;
      default:          last_pc = 2'd0;
    endcase
  end

  // Operands for the multiply that follows the current step's post-processing.
  always_comb begin
    case (step)
      3'd1:    begin nxt_a = y; nxt_b = z; end
      3'd2:    begin nxt_a = x; nxt_b = a; end
      3'd3:    begin nxt_a = a; nxt_b = a; end
      default: begin nxt_a = d; nxt_b = d; end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      step        <= 3'd0;
      pc          <= 2'd0;
      o_rdy       <= 1'b1;
      o_val       <= 1'b0;
      o_pt        <= '0;
      o_mul_a     <= '0;
      o_mul_b     <= '0;
      o_mul_val   <= 1'b0;
      o_mul_c_rdy <= 1'b0;
      x <= '0; y <= '0; z <= '0; a <= '0; b <= '0;
      c <= '0; d <= '0; xo <= '0; zo <= '0; p0 <= '0;
    end else begin
      case (state)
        S_IDLE: if (i_val) begin
          x     <= in_x;
          y     <= in_y;
          z     <= in_z;
          o_rdy <= 1'b0;
          if (in_z == '0) begin
            o_pt  <= i_pt;
            o_val <= 1'b1;
            state <= S_DONE;
          end else begin
            step      <= 3'd0;
            pc        <= 2'd0;
            o_mul_a   <= in_y;
            o_mul_b   <= in_y;
            o_mul_val <= 1'b1;
            state     <= S_MUL;
          end
        end
        S_MUL: begin
          if (!o_mul_val) begin
            o_mul_a   <= d;
            o_mul_b   <= r;
            o_mul_val <= 1'b1;
          end else if (i_mul_rdy) begin
            o_mul_val   <= 1'b0;
            o_mul_c_rdy <= 1'b1;
            state       <= S_WAIT;
          end
        end
        S_WAIT: if (i_mul_c_val) begin
          o_mul_c_rdy <= 1'b0;
          if (step == 3'd0) begin
            a         <= i_mul_c;
            step      <= 3'd1;
            o_mul_a   <= x;
            o_mul_b   <= x;
            o_mul_val <= 1'b1;
            state     <= S_MUL;
          end else begin
            p0    <= i_mul_c;
            pc    <= 2'd0;
            state <= S_POST;
          end
        end
        S_POST: begin
          case (step)
            3'd1:    d  <= r;
            3'd2:    zo <= r;
            3'd3:    b  <= r;
            3'd4:    c  <= r;
            3'd5:    xo <= r;
            default: ;
          endcase
          if (pc == last_pc) begin
            pc <= 2'd0;
            if (step == 3'd6) begin
              o_pt  <= {xo, r, zo};
              o_val <= 1'b1;
              state <= S_DONE;
            end else begin
              step      <= step + 3'd1;
              o_mul_a   <= nxt_a;
              o_mul_b   <= nxt_b;
              o_mul_val <= (step != 3'd5);
              state     <= S_MUL;
            end
          end else begin
            pc <= pc + 2'd1;
          end
        end
        S_DONE: if (i_rdy) begin
          o_val <= 1'b0;
          o_rdy <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ec_point_dbl_jb_seq.sv
// Directed bench for the Jacobian doubler: secp256k1 instance with a modelled
// multiplier plus an 8-bit P=251 instance for the small-field sweep.
module tb_ec_point_dbl_jb_seq;
  localparam logic [255:0] P256 = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
  localparam logic [255:0] GX   = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
  localparam logic [255:0] GY   = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
  localparam logic [255:0] G2X  = 256'hC6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5;
  localparam logic [255:0] G2Y  = 256'h1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [767:0] pt_in = '0;
  logic         pt_in_val = 1'b0;
  logic         pt_in_rdy;
  logic [767:0] pt_out;
  logic         pt_out_val;
  logic         pt_out_rdy = 1'b0;
  logic [255:0] mul_a, mul_b;
  logic         mul_val;
  logic         mul_rdy = 1'b1;
  logic [255:0] mul_c = '0;
  logic         mul_c_val = 1'b0;
  logic         mul_c_rdy;
  logic [2:0]   dbg_state;

  logic [23:0]  s_pt_in = '0;
  logic         s_pt_in_val = 1'b0;
  logic         s_pt_in_rdy;
  logic [23:0]  s_pt_out;
  logic         s_pt_out_val;
  logic         s_pt_out_rdy = 1'b0;
  logic [7:0]   s_mul_a, s_mul_b;
  logic         s_mul_val;
  logic         s_mul_rdy = 1'b1;
  logic [7:0]   s_mul_c = '0;
  logic         s_mul_c_val = 1'b0;
  logic         s_mul_c_rdy;
  logic [2:0]   s_dbg_state;

  int checks = 0;
  int errors = 0;
  int n_req = 0;
  bit mul_val_seen = 1'b0;
  int req_stall = 0;
  int rsp_gap_max = 0;
  logic [767:0] exp_q[$];

  always #5 clk = ~clk;

  ec_point_dbl_jb_seq u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pt(pt_in), .i_val(pt_in_val), .o_rdy(pt_in_rdy),
    .o_pt(pt_out), .o_val(pt_out_val), .i_rdy(pt_out_rdy),
    .o_mul_a(mul_a), .o_mul_b(mul_b), .o_mul_val(mul_val), .i_mul_rdy(mul_rdy),
    .i_mul_c(mul_c), .i_mul_c_val(mul_c_val), .o_mul_c_rdy(mul_c_rdy), .o_dbg_state(dbg_state)
  );

  ec_point_dbl_jb_seq #(.DAT_BITS(8), .P(8'd251)) u_dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_pt(s_pt_in), .i_val(s_pt_in_val), .o_rdy(s_pt_in_rdy),
    .o_pt(s_pt_out), .o_val(s_pt_out_val), .i_rdy(s_pt_out_rdy),
    .o_mul_a(s_mul_a), .o_mul_b(s_mul_b), .o_mul_val(s_mul_val), .i_mul_rdy(s_mul_rdy),
    .i_mul_c(s_mul_c), .i_mul_c_val(s_mul_c_val), .o_mul_c_rdy(s_mul_c_rdy), .o_dbg_state(s_dbg_state)
  );

  function automatic logic [255:0] f_mul(input logic [255:0] fa, input logic [255:0] fb,
                                         input logic [255:0] p);
    logic [511:0] aw, bw, pw, t;
    aw = {256'd0, fa};
    bw = {256'd0, fb};
    pw = {256'd0, p};
    t  = (aw * bw) % pw;
    return t[255:0];
  endfunction

  function automatic logic [255:0] f_sub(input logic [255:0] fa, input logic [255:0] fb,
                                         input logic [255:0] p);
    logic [256:0] s;
    s = ({1'b0, fa} + {1'b0, p} - {1'b0, fb}) % {1'b0, p};
    return s[255:0];
  endfunction

  // Reference doubling straight from the curve formulas, using plain % arithmetic.
  function automatic logic [767:0] model_dbl(input logic [255:0] mx, input logic [255:0] my,
                                             input logic [255:0] mz, input logic [255:0] p);
    logic [255:0] ma, mb, mc, md, rx, ry, rz;
    if (mz == '0) return {mx, my, mz};
    ma = f_mul(my, my, p);
    mb = f_mul(256'd4, f_mul(mx, ma, p), p);
    mc = f_mul(256'd8, f_mul(ma, ma, p), p);
    md = f_mul(256'd3, f_mul(mx, mx, p), p);
    rx = f_sub(f_mul(md, md, p), f_mul(256'd2, mb, p), p);
    ry = f_sub(f_mul(md, f_sub(mb, rx, p), p), mc, p);
    rz = f_mul(256'd2, f_mul(my, mz, p), p);
    return {rx, ry, rz};
  endfunction

  function automatic logic [255:0] rand_fe();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    if (v >= P256) v = v - P256;
    return v;
  endfunction

  // Multiplier model for the 256-bit instance; inputs change 1 time unit after posedge.
  initial begin : mul_agent
    bit req_fire, rsp_fire, pending;
    logic [255:0] ra, rb, prod;
    int gap;
    pending = 1'b0;
    gap = 0;
    prod = '0;
    forever begin
      @(negedge clk);
      req_fire = mul_val && mul_rdy;
      rsp_fire = mul_c_val && mul_c_rdy;
      ra = mul_a;
      rb = mul_b;
      if (mul_val) mul_val_seen = 1'b1;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        pending = 1'b0;
        mul_c_val = 1'b0;
      end else begin
        if (rsp_fire) begin
          mul_c_val = 1'b0;
          pending = 1'b0;
        end
        if (req_fire) begin
          pending = 1'b1;
          prod = f_mul(ra, rb, P256);
          gap = (rsp_gap_max > 0) ? int'($urandom_range(0, rsp_gap_max)) : 0;
          n_req++;
        end
        if (pending && !mul_c_val) begin
          if (gap == 0) begin
            mul_c_val = 1'b1;
            mul_c = prod;
          end else gap--;
        end
      end
      mul_rdy = (req_stall == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
    end
  end

  // Zero-wait multiplier model for the 8-bit instance.
  initial begin : s_mul_agent
    bit req_fire, rsp_fire;
    logic [255:0] prod;
    forever begin
      @(negedge clk);
      req_fire = s_mul_val && s_mul_rdy;
      rsp_fire = s_mul_c_val && s_mul_c_rdy;
      prod = f_mul({248'd0, s_mul_a}, {248'd0, s_mul_b}, 256'd251);
      @(posedge clk);
      #1;
      if (!rst_n || rsp_fire) s_mul_c_val = 1'b0;
      if (rst_n && req_fire) begin
        s_mul_c_val = 1'b1;
        s_mul_c = prod[7:0];
      end
    end
  end

  task automatic send_pt(input logic [767:0] pt, output bit ok);
    pt_in = pt;
    pt_in_val = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge clk);
      if (pt_in_rdy) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    pt_in_val = 1'b0;
  endtask

  task automatic recv_pt(input int budget, output logic [767:0] pt, output int lat, output bit ok);
    ok = 1'b0;
    lat = 0;
    pt = '0;
    while (!ok && lat < budget) begin
      @(negedge clk);
      lat++;
      if (pt_out_val) begin
        ok = 1'b1;
        pt = pt_out;
      end
    end
  endtask

  task automatic ack_out();
    pt_out_rdy = 1'b1;
    @(posedge clk);
    #1;
    pt_out_rdy = 1'b0;
  endtask

  task automatic send8(input logic [23:0] pt, output bit ok);
    s_pt_in = pt;
    s_pt_in_val = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (s_pt_in_rdy) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    s_pt_in_val = 1'b0;
  endtask

  task automatic recv8(output logic [23:0] pt, output bit ok);
    ok = 1'b0;
    pt = '0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (s_pt_out_val) begin
        ok = 1'b1;
        pt = s_pt_out;
      end
    end
    s_pt_out_rdy = 1'b1;
    @(posedge clk);
    #1;
    s_pt_out_rdy = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (pt_in_rdy !== 1'b1) begin errors++; $display("FAIL reset_o_rdy got %b exp 1", pt_in_rdy); end
    checks++; if (pt_out_val !== 1'b0) begin errors++; $display("FAIL reset_o_val got %b exp 0", pt_out_val); end
    checks++; if (mul_val !== 1'b0) begin errors++; $display("FAIL reset_mul_val got %b exp 0", mul_val); end
    checks++; if (mul_c_rdy !== 1'b0) begin errors++; $display("FAIL reset_mul_c_rdy got %b exp 0", mul_c_rdy); end
    checks++; if (pt_out !== '0) begin errors++; $display("FAIL reset_o_pt got %h exp 0", pt_out); end
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    checks++; if (s_pt_in_rdy !== 1'b1) begin errors++; $display("FAIL reset8_o_rdy got %b exp 1", s_pt_in_rdy); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_generator();
    logic [767:0] got, exp;
    logic [255:0] z2, z3;
    int lat;
    bit ok_in, ok_out;
    n_req = 0;
    exp = model_dbl(GX, GY, 256'd1, P256);
    send_pt({GX, GY, 256'd1}, ok_in);
    recv_pt(500, got, lat, ok_out);
    checks++; if (!(ok_in && ok_out)) begin errors++; $display("FAIL gen_timeout got in=%b out=%b exp 1 1", ok_in, ok_out); end
    checks++; if (lat != 27) begin errors++; $display("FAIL gen_latency got %0d exp 27", lat); end
    checks++; if (got !== exp) begin errors++; $display("FAIL gen_model got %h exp %h", got, exp); end
    z2 = f_mul(got[255:0], got[255:0], P256);
    z3 = f_mul(z2, got[255:0], P256);
    checks++; if (got[767:512] !== f_mul(G2X, z2, P256)) begin errors++; $display("FAIL gen_affine_x got %h exp %h", got[767:512], f_mul(G2X, z2, P256)); end
    checks++; if (got[511:256] !== f_mul(G2Y, z3, P256)) begin errors++; $display("FAIL gen_affine_y got %h exp %h", got[511:256], f_mul(G2Y, z3, P256)); end
    checks++; if (n_req != 7) begin errors++; $display("FAIL gen_req_count got %0d exp 7", n_req); end
    ack_out();
    @(negedge clk);
    checks++; if (pt_in_rdy !== 1'b1) begin errors++; $display("FAIL gen_rdy_after_ack got %b exp 1", pt_in_rdy); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_infinity();
    logic [767:0] got;
    int lat;
    bit ok_in, ok_out;
    n_req = 0;
    mul_val_seen = 1'b0;
    send_pt({256'd5, 256'd9, 256'd0}, ok_in);
    recv_pt(50, got, lat, ok_out);
    checks++; if (!(ok_in && ok_out)) begin errors++; $display("FAIL inf_timeout got in=%b out=%b exp 1 1", ok_in, ok_out); end
    checks++; if (lat != 1) begin errors++; $display("FAIL inf_latency got %0d exp 1", lat); end
    checks++; if (got !== {256'd5, 256'd9, 256'd0}) begin errors++; $display("FAIL inf_passthru got %h exp x=5 y=9 z=0", got); end
    checks++; if (mul_val_seen || n_req != 0) begin errors++; $display("FAIL inf_no_mul got seen=%b reqs=%0d exp 0 0", mul_val_seen, n_req); end
    ack_out();
  endtask

  task automatic test_y_zero();
    logic [767:0] got;
    int lat;
    bit ok_in, ok_out;
    // D = 27, X' = 729, Y' = -27*729 = P - 19683
    send_pt({256'd3, 256'd0, 256'd1}, ok_in);
    recv_pt(500, got, lat, ok_out);
    checks++; if (!(ok_in && ok_out)) begin errors++; $display("FAIL yzero_timeout got in=%b out=%b exp 1 1", ok_in, ok_out); end
    checks++; if (got[255:0] !== '0) begin errors++; $display("FAIL yzero_z got %h exp 0", got[255:0]); end
    checks++; if (got[767:512] !== 256'd729) begin errors++; $display("FAIL yzero_x got %h exp 2d9", got[767:512]); end
    checks++; if (got[511:256] !== 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFAF4C) begin
      errors++; $display("FAIL yzero_y got %h exp P-19683", got[511:256]);
    end
    ack_out();
  endtask

  task automatic test_random_stall();
    logic [767:0] got, first, exp;
    logic [255:0] rx, ry, rz;
    int lat;
    bit ok_in, ok_out, stable;
    req_stall = 1;
    rsp_gap_max = 10;
    for (int i = 0; i < 100; i++) begin
      rx = rand_fe();
      ry = rand_fe();
      rz = rand_fe();
      if (rz == '0) rz = 256'd1;
      exp_q.push_back(model_dbl(rx, ry, rz, P256));
      n_req = 0;
      send_pt({rx, ry, rz}, ok_in);
      recv_pt(3000, got, lat, ok_out);
      first = got;
      stable = 1'b1;
      for (int h = 0; h < 20; h++) begin
        @(negedge clk);
        if (pt_out !== first || pt_out_val !== 1'b1) stable = 1'b0;
      end
      exp = exp_q.pop_front();
      checks++; if (!(ok_in && ok_out)) begin errors++; $display("FAIL rnd_timeout[%0d] got in=%b out=%b exp 1 1", i, ok_in, ok_out); end
      checks++; if (got !== exp) begin errors++; $display("FAIL rnd_model[%0d] got %h exp %h", i, got, exp); end
      checks++; if (!stable) begin errors++; $display("FAIL rnd_hold_stable[%0d] got unstable exp stable", i); end
      checks++; if (n_req != 7) begin errors++; $display("FAIL rnd_req_count[%0d] got %0d exp 7", i, n_req); end
      ack_out();
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    req_stall = 0;
    rsp_gap_max = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_op();
    logic [767:0] got, exp;
    int lat;
    bit ok_in, ok_out;
    n_req = 0;
    send_pt({GX, GY, 256'd1}, ok_in);
    for (int k = 0; k < 500 && n_req < 4; k++) @(negedge clk);
    checks++; if (n_req < 4) begin errors++; $display("FAIL rst_reach_step3 got %0d reqs exp 4", n_req); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (pt_in_rdy !== 1'b1 || pt_out_val !== 1'b0) begin errors++; $display("FAIL rst_mid_hs got rdy=%b val=%b exp 1 0", pt_in_rdy, pt_out_val); end
    checks++; if (mul_val !== 1'b0 || mul_c_rdy !== 1'b0) begin errors++; $display("FAIL rst_mid_mul got val=%b c_rdy=%b exp 0 0", mul_val, mul_c_rdy); end
    checks++; if (pt_out !== '0) begin errors++; $display("FAIL rst_mid_o_pt got %h exp 0", pt_out); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_req = 0;
    exp = model_dbl(GX, GY, 256'd1, P256);
    send_pt({GX, GY, 256'd1}, ok_in);
    recv_pt(500, got, lat, ok_out);
    checks++; if (!(ok_in && ok_out)) begin errors++; $display("FAIL rst_after_timeout got in=%b out=%b exp 1 1", ok_in, ok_out); end
    checks++; if (got !== exp) begin errors++; $display("FAIL rst_after_model got %h exp %h", got, exp); end
    checks++; if (n_req != 7) begin errors++; $display("FAIL rst_after_req_count got %0d exp 7", n_req); end
    ack_out();
  endtask

  task automatic test_small_field();
    logic [767:0] ex;
    logic [23:0]  exp8, got8;
    logic [7:0]   vx, vy;
    bit ok_in, ok_out, in_range;
    for (int xi = 0; xi < 11; xi++) begin
      for (int yi = 0; yi < 11; yi++) begin
        vx = 8'(xi * 25);
        vy = 8'(yi * 25);
        ex = model_dbl({248'd0, vx}, {248'd0, vy}, 256'd1, 256'd251);
        exp8 = {ex[519:512], ex[263:256], ex[7:0]};
        send8({vx, vy, 8'd1}, ok_in);
        recv8(got8, ok_out);
        in_range = (got8[23:16] < 8'd251) && (got8[15:8] < 8'd251) && (got8[7:0] < 8'd251);
        checks++; if (!(ok_in && ok_out)) begin errors++; $display("FAIL f251_timeout x=%0d y=%0d got in=%b out=%b exp 1 1", vx, vy, ok_in, ok_out); end
        checks++; if (got8 !== exp8) begin errors++; $display("FAIL f251_model x=%0d y=%0d got %h exp %h", vx, vy, got8, exp8); end
        checks++; if (!in_range) begin errors++; $display("FAIL f251_range x=%0d y=%0d got %h exp all < fb", vx, vy, got8); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_generator();
    test_infinity();
    test_y_zero();
    test_random_stall();
    test_reset_mid_op();
    test_small_field();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
